// File: rtl/wb_ssram_arbiter.sv
// wb_ssram_arbiter: two-master Wishbone classic arbiter in front of one SSRAM controller slave
// Ports: clk_i/rst_n_i clock and async active-low reset; m0_* instruction-fetch master,
// m1_* data master (cyc/stb/we/sel/adr/dat in, dat/ack/err out); s_* slave side
// (cyc/stb/we/sel/adr/dat out, dat/ack in); grant_o one-hot current owner.
module wb_ssram_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic [7:0]  timer_q, timer_d;
  logic        drop_q, drop_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        req0, req1, win1, busy, g1, drop, tout;
  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  // m1 wins when alone, or on a tie under round-robin when m0 won last
  assign win1 = req1 & (~req0 | ((FIXED_PRIO == 0) & ~last_q));
  assign busy = state_q == BUSY;
  assign g1   = grant_q[1];
  // once the owner abandons its cycle, the slave keeps seeing the values captured at grant
  assign drop = drop_q | ~(g1 ? m1_cyc_i : m0_cyc_i);
  assign tout = busy & ~s_ack_i & (timer_q + 8'd1 == TO);
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    timer_d = timer_q;
    drop_d  = drop_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: if (req0 | req1) begin
        state_d = BUSY;
        grant_d = win1 ? 2'b10 : 2'b01;
        last_d  = win1;
        timer_d = 8'd0;
        drop_d  = 1'b0;
        we_d    = win1 ? m1_we_i  : m0_we_i;
        sel_d   = win1 ? m1_sel_i : m0_sel_i;
        adr_d   = win1 ? m1_adr_i : m0_adr_i;
        dat_d   = win1 ? m1_dat_i : m0_dat_i;
      end
      BUSY: begin
        timer_d = timer_q + 8'd1;
        drop_d  = drop;
        state_d = (s_ack_i | tout) ? RELEASE : BUSY;
      end
      RELEASE: if (!s_ack_i) begin
        state_d = IDLE;
        grant_d = 2'b00;
        timer_d = 8'd0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      timer_q <= 8'd0;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      drop_q  <= drop_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  assign s_cyc_o  = busy;
  assign s_stb_o  = busy;
  assign s_we_o   = busy & (drop ? we_q : (g1 ? m1_we_i : m0_we_i));
  assign s_sel_o  = busy ? (drop ? sel_q : (g1 ? m1_sel_i : m0_sel_i)) : 4'd0;
  assign s_adr_o  = busy ? (drop ? adr_q : (g1 ? m1_adr_i : m0_adr_i)) : 32'd0;
  assign s_dat_o  = busy ? (drop ? dat_q : (g1 ? m1_dat_i : m0_dat_i)) : 32'd0;
  assign m0_ack_o = busy & s_ack_i & ~drop & grant_q[0];
  assign m1_ack_o = busy & s_ack_i & ~drop & grant_q[1];
  assign m0_err_o = tout & grant_q[0];
  assign m1_err_o = tout & grant_q[1];
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = grant_q;
endmodule

// File: tb/tb_wb_ssram_arbiter.sv
// tb_wb_ssram_arbiter: directed checks of a round-robin and a fixed-priority arbiter driven in lockstep
module tb_wb_ssram_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0, s_ack = 0;
  logic [3:0]  m0_sel = 0, m1_sel = 0;
  logic [31:0] m0_adr = 0, m0_dat = 0, m1_adr = 0, m1_dat = 0, s_dat = 0;
  logic [31:0] a_m0_dat, a_m1_dat, a_s_adr, a_s_dat, b_m0_dat, b_m1_dat, b_s_adr, b_s_dat;
  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_cyc, a_s_stb, a_s_we;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_cyc, b_s_stb, b_s_we;
  logic [3:0]  a_s_sel, b_s_sel;
  logic [1:0]  a_grant, b_grant;
  int          n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  wb_ssram_arbiter #(.FIXED_PRIO(0), .TIMEOUT(16)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_dat_o(a_m0_dat), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_dat_o(a_m1_dat), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_sel_o(a_s_sel), .s_adr_o(a_s_adr),
    .s_dat_o(a_s_dat), .s_dat_i(s_dat), .s_ack_i(s_ack), .grant_o(a_grant));
  wb_ssram_arbiter #(.FIXED_PRIO(1), .TIMEOUT(16)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_dat_o(b_m0_dat), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_dat_o(b_m1_dat), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_sel_o(b_s_sel), .s_adr_o(b_s_adr),
    .s_dat_o(b_s_dat), .s_dat_i(s_dat), .s_ack_i(s_ack), .grant_o(b_grant));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_a_grant"}, a_grant, 2'b00);
    chk({tag, "_b_grant"}, b_grant, 2'b00);
    chk({tag, "_a_cyc"}, a_s_cyc, 0);
    chk({tag, "_b_stb"}, b_s_stb, 0);
    chk({tag, "_a_ackerr"}, {a_m0_ack, a_m1_ack, a_m0_err, a_m1_err}, 0);
    chk({tag, "_b_ackerr"}, {b_m0_ack, b_m1_ack, b_m0_err, b_m1_err}, 0);
  endtask
  task automatic chk_busy(input string tag, input logic [1:0] ga, input logic [1:0] gb);
    chk({tag, "_a_cycstb"}, {a_s_cyc, a_s_stb}, 2'b11);
    chk({tag, "_b_cycstb"}, {b_s_cyc, b_s_stb}, 2'b11);
    chk({tag, "_a_grant"}, a_grant, ga);
    chk({tag, "_b_grant"}, b_grant, gb);
  endtask
  initial begin
    #1 chk_idle("reset");
    chk("reset_a_adr", a_s_adr, 0);
    tick(); tick(); rst_n = 1'b1;
    // single m0 read, slave acks in the fifth BUSY cycle
    tick();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hf; m0_adr = 32'h100;
    #1 chk_idle("t1_req");
    tick(); chk_busy("t1_busy", 2'b01, 2'b01);
    chk("t1_adr", a_s_adr, 32'h100);
    chk("t1_sel", a_s_sel, 4'hf);
    chk("t1_we", a_s_we, 0);
    repeat (3) begin
      tick();
      chk("t1_wait_stb", b_s_stb, 1);
      chk("t1_wait_ack", a_m0_ack, 0);
    end
    tick(); s_ack = 1; s_dat = 32'hdeadbeef;
    #1 chk("t1_a_m0_ack", a_m0_ack, 1);
    chk("t1_b_m0_ack", b_m0_ack, 1);
    chk("t1_a_m1_ack", a_m1_ack, 0);
    chk("t1_m0_dat", a_m0_dat, 32'hdeadbeef);
    chk("t1_m1_dat", b_m1_dat, 32'hdeadbeef);
    chk("t1_err", {a_m0_err, a_m1_err}, 0);
    tick(); m0_cyc = 0; m0_stb = 0;
    #1 chk("t1_rel_stb", a_s_stb, 0);
    chk("t1_rel_grant", a_grant, 2'b01);
    chk("t1_rel_ack", a_m0_ack, 0);
    tick();
    chk("t1_rel_hold_grant", b_grant, 2'b01);
    chk("t1_rel_hold_cyc", b_s_cyc, 0);
    s_ack = 0;
    tick(); chk_idle("t1_idle");
    // fresh reset, then both masters hold requests through five transactions
    rst_n = 0; tick(); rst_n = 1;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100; m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_busy("t2_busy", (i % 2) ? 2'b10 : 2'b01, 2'b01);
      chk("t2_a_adr", a_s_adr, (i % 2) ? 32'h200 : 32'h100);
      chk("t2_b_adr", b_s_adr, 32'h100);
      s_ack = 1;
      #1 chk("t2_a_acks", {a_m1_ack, a_m0_ack}, (i % 2) ? 2'b10 : 2'b01);
      chk("t2_b_acks", {b_m1_ack, b_m0_ack}, 2'b01);
      tick(); s_ack = 0;
      #1 chk("t2_rel_cyc", a_s_cyc, 0);
      chk("t2_rel_grant", a_grant, (i % 2) ? 2'b10 : 2'b01);
      tick(); chk_idle("t2_gap");
    end
    m0_cyc = 0; m0_stb = 0;
    tick(); chk_busy("t2_m1only", 2'b10, 2'b10);
    chk("t2_m1only_adr", b_s_adr, 32'h200);
    s_ack = 1;
    #1 chk("t2_b_m1_ack", {b_m1_ack, b_m0_ack}, 2'b10);
    tick(); s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick(); chk_idle("t2_end");
    // m1 read never acked: timeout error in BUSY cycle 16
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
    tick(); chk_busy("t3_busy", 2'b10, 2'b10);
    chk("t3_err_c1", a_m1_err, 0);
    for (int k = 2; k <= 16; k++) begin
      tick();
      chk("t3_a_err", a_m1_err, k == 16);
      chk("t3_b_err", b_m1_err, k == 16);
      chk("t3_stb", a_s_stb, 1);
      chk("t3_noack", {a_m1_ack, a_m0_err}, 0);
    end
    tick(); m1_cyc = 0; m1_stb = 0;
    #1 chk("t3_rel_stb", a_s_stb, 0);
    chk("t3_rel_err", a_m1_err, 0);
    chk("t3_rel_grant", a_grant, 2'b10);
    tick(); chk_idle("t3_idle");
    // m1 write abandons its cycle mid-transfer
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'h3; m1_adr = 32'h2000_0040; m1_dat = 32'hcafef00d;
    tick(); chk_busy("t4_busy", 2'b10, 2'b10);
    chk("t4_we", a_s_we, 1);
    chk("t4_sel", a_s_sel, 4'h3);
    chk("t4_dat", a_s_dat, 32'hcafef00d);
    tick();
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0; m1_adr = 32'hffff_ffff; m1_dat = 0;
    #1 chk("t4_drop_stb", a_s_stb, 1);
    chk("t4_drop_adr", a_s_adr, 32'h2000_0040);
    chk("t4_drop_dat", b_s_dat, 32'hcafef00d);
    chk("t4_drop_we", a_s_we, 1);
    chk("t4_drop_sel", b_s_sel, 4'h3);
    tick();
    chk("t4_hold_stb", b_s_stb, 1);
    chk("t4_hold_adr", b_s_adr, 32'h2000_0040);
    s_ack = 1;
    #1 chk("t4_swallow", {a_m1_ack, b_m1_ack, a_m0_ack, a_m1_err}, 0);
    tick(); s_ack = 0;
    #1 chk("t4_rel_stb", a_s_stb, 0);
    tick(); chk_idle("t4_idle");
    // reset asserted in the middle of a transfer
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h400;
    tick(); chk_busy("t5_busy", 2'b01, 2'b01);
    rst_n = 0; s_ack = 1;
    #1 chk_idle("t5_reset");
    chk("t5_reset_adr", a_s_adr, 0);
    tick(); rst_n = 1; s_ack = 0;
    tick(); chk_busy("t5_after", 2'b01, 2'b01);
    chk("t5_adr", a_s_adr, 32'h400);
    s_ack = 1; s_dat = 32'h1234_5678;
    #1 chk("t5_ack", {a_m0_ack, b_m0_ack}, 2'b11);
    chk("t5_dat", b_m0_dat, 32'h1234_5678);
    tick(); m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick(); chk_idle("t5_idle");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
